// File: rtl/riscv_mem_bridge_pkg.sv
// Shared types and constants for the core-to-RAM memory bridge.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package riscv_mem_pkg;

    // Bridge sequencing states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RAM_REQ = 2'd1,
        RESP    = 2'd2
    } state_t;

    // Where a request lands after address decode
    typedef enum logic [1:0] {
        REG_RAM     = 2'd0,
        REG_CONSOLE = 2'd1,
        REG_STATUS  = 2'd2,
        REG_FAULT   = 2'd3
    } region_t;

    // MMIO register offsets from MMIO_BASE
    localparam logic [31:0] CONSOLE_OFS    = 32'h0000_0000;
    localparam logic [31:0] STATUS_OFS     = 32'h0000_0004;

    // Status write value that marks the test as passed
    localparam logic [31:0] TEST_PASS_CODE = 32'h0000_0001;

    // Registered copy of a core request
    typedef struct packed {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

endpackage

// File: rtl/riscv_mem_bridge_if.sv
// Core-side native memory port (valid/ready, byte addressed).
// Latency: n/a, wires only.
// Backpressure: master holds cpu_valid and fields until the slave pulses cpu_ready.
interface riscv_mem_bridge_if;

    logic        cpu_valid;
    logic        cpu_instr;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_wstrb;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;

    // The core drives requests
    modport master (
        output cpu_valid,
        output cpu_instr,
        output cpu_addr,
        output cpu_wdata,
        output cpu_wstrb,
        input  cpu_rdata,
        input  cpu_ready
    );

    // The bridge answers them
    modport slave (
        input  cpu_valid,
        input  cpu_instr,
        input  cpu_addr,
        input  cpu_wdata,
        input  cpu_wstrb,
        output cpu_rdata,
        output cpu_ready
    );

endinterface

// File: rtl/riscv_mem_bridge_decode.sv
// Classifies a byte address / fetch flag into RAM, console, status or fault.
// Latency: combinational.
// Backpressure: none.
module riscv_addr_decode
    import riscv_mem_pkg::*;
#(
    parameter int          ADDR_WIDTH = 16,
    parameter logic [31:0] MMIO_BASE  = 32'h1000_0000
) (
    input  logic [31:0] addr,
    input  logic        instr,
    output region_t     region
);

    // RAM occupies bytes 0 .. RAM_BYTES-1; one extra bit so the bound never overflows
    localparam logic [32:0] RAM_BYTES = 33'd1 << (ADDR_WIDTH + 2);

    // Priority decode: alignment first, then RAM, then data-only MMIO
    always_comb begin
        region = REG_FAULT;
        if (addr[1:0] != 2'b00) begin
            region = REG_FAULT;
        end else if ({1'b0, addr} < RAM_BYTES) begin
            region = REG_RAM;
        end else if (!instr && (addr == MMIO_BASE + CONSOLE_OFS)) begin
            region = REG_CONSOLE;
        end else if (!instr && (addr == MMIO_BASE + STATUS_OFS)) begin
            region = REG_STATUS;
        end
    end

endmodule

// File: rtl/riscv_mem_bridge.sv
// Bridges the core memory port to a word-addressed RAM plus console/status MMIO.
// Latency: RAM completes in cycle 2, MMIO/fault in cycle 1 after acceptance.
// Backpressure: one request in flight; core waits on cpu_ready, RAM never stalls.
module riscv_mem_bridge
    import riscv_mem_pkg::*;
#(
    parameter int          ADDR_WIDTH = 16,
    parameter logic [31:0] MMIO_BASE  = 32'h1000_0000
) (
    input  logic                  clk,
    input  logic                  resetn,
    riscv_mem_bridge_if.slave     cpu,
    output logic                  ram_valid,
    output logic                  ram_instr,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_wdata,
    output logic [3:0]            ram_wstrb,
    input  logic [31:0]           ram_rdata,
    output logic                  console_valid,
    output logic [7:0]            console_data,
    output logic                  test_done,
    output logic                  test_pass,
    output logic                  fault,
    output logic [31:0]           fault_addr,
    output logic [31:0]           req_count
);

    state_t  state_q;
    state_t  state_d;
    req_t    req_q;
    region_t region_q;
    region_t dec_region;
    logic    accept;

    riscv_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .MMIO_BASE  (MMIO_BASE)
    ) u_decode (
        .addr   (cpu.cpu_addr),
        .instr  (cpu.cpu_instr),
        .region (dec_region)
    );

    assign accept = (state_q == IDLE) && cpu.cpu_valid;

    // State register; reset abandons whatever request is in flight
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and strobes; strobes are masked by reset so an abandoned
    // RAM write never reaches the array
    always_comb begin
        state_d       = state_q;
        ram_valid     = 1'b0;
        cpu.cpu_ready = 1'b0;
        console_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cpu.cpu_valid) begin
                    state_d = (dec_region == REG_RAM) ? RAM_REQ : RESP;
                end
            end
            RAM_REQ: begin
                ram_valid = resetn;
                state_d   = RESP;
            end
            RESP: begin
                cpu.cpu_ready = resetn;
                console_valid = resetn && (region_q == REG_CONSOLE) && req_q.wstrb[0];
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Capture the request in IDLE; later states look only at this copy
    always_ff @(posedge clk) begin
        if (!resetn) begin
            req_q    <= '0;
            region_q <= REG_RAM;
        end else if (accept) begin
            req_q.instr <= cpu.cpu_instr;
            req_q.addr  <= cpu.cpu_addr;
            req_q.wdata <= cpu.cpu_wdata;
            req_q.wstrb <= cpu.cpu_wstrb;
            region_q    <= dec_region;
        end
    end

    assign ram_instr = req_q.instr;
    assign ram_addr  = req_q.addr[ADDR_WIDTH+1:2];
    assign ram_wdata = req_q.wdata;
    assign ram_wstrb = req_q.wstrb;

    assign console_data = console_valid ? req_q.wdata[7:0] : 8'h00;

    // Response data mux, zero whenever no completion is being signalled
    always_comb begin
        cpu.cpu_rdata = 32'h0;
        if (cpu.cpu_ready) begin
            unique case (region_q)
                REG_RAM:     cpu.cpu_rdata = ram_rdata;
                REG_STATUS:  cpu.cpu_rdata = {30'b0, test_pass, test_done};
                default:     cpu.cpu_rdata = 32'h0;
            endcase
        end
    end

    // Status register: any write marks done, pass tracks the latest value written
    always_ff @(posedge clk) begin
        if (!resetn) begin
            test_done <= 1'b0;
            test_pass <= 1'b0;
        end else if (cpu.cpu_ready && (region_q == REG_STATUS) && (req_q.wstrb != 4'h0)) begin
            test_done <= 1'b1;
            test_pass <= (req_q.wdata == TEST_PASS_CODE);
        end
    end

    // Sticky fault flag; the address of the first offender is kept
    always_ff @(posedge clk) begin
        if (!resetn) begin
            fault      <= 1'b0;
            fault_addr <= 32'h0;
        end else if (cpu.cpu_ready && (region_q == REG_FAULT)) begin
            fault <= 1'b1;
            if (!fault) begin
                fault_addr <= req_q.addr;
            end
        end
    end

    // Completed-request counter, free-running wrap
    always_ff @(posedge clk) begin
        if (!resetn) begin
            req_count <= 32'h0;
        end else if (cpu.cpu_ready) begin
            req_count <= req_count + 32'h1;
        end
    end

endmodule

// File: tb/tb_riscv_mem_bridge.sv
// Bench for riscv_mem_bridge: directed vector table, reset abort, random RAM traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_riscv_mem_bridge;
    import riscv_mem_pkg::*;

    localparam int          AW    = 16;
    localparam logic [31:0] MBASE = 32'h1000_0000;

    logic        clk;
    logic        resetn;
    logic        ram_valid;
    logic        ram_instr;
    logic [15:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_wstrb;
    logic [31:0] ram_rdata;
    logic        console_valid;
    logic [7:0]  console_data;
    logic        test_done;
    logic        test_pass;
    logic        fault;
    logic [31:0] fault_addr;
    logic [31:0] req_count;

    logic [31:0] dec_addr;
    logic        dec_instr;
    region_t     dec_region;

    int checks = 0;
    int errors = 0;
    int cycle_cnt = 0;

    riscv_mem_bridge_if cpu_bus();

    riscv_mem_bridge #(.ADDR_WIDTH(AW), .MMIO_BASE(MBASE)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .cpu           (cpu_bus),
        .ram_valid     (ram_valid),
        .ram_instr     (ram_instr),
        .ram_addr      (ram_addr),
        .ram_wdata     (ram_wdata),
        .ram_wstrb     (ram_wstrb),
        .ram_rdata     (ram_rdata),
        .console_valid (console_valid),
        .console_data  (console_data),
        .test_done     (test_done),
        .test_pass     (test_pass),
        .fault         (fault),
        .fault_addr    (fault_addr),
        .req_count     (req_count)
    );

    riscv_addr_decode #(.ADDR_WIDTH(AW), .MMIO_BASE(MBASE)) u_ref_dec (
        .addr   (dec_addr),
        .instr  (dec_instr),
        .region (dec_region)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // Single-port RAM: registered read of the old word, byte-masked write
    logic [31:0] tb_mem [0:65535];
    initial begin
        for (int i = 0; i < 65536; i++) tb_mem[i] = 32'h0;
    end
    always @(posedge clk) begin
        if (ram_valid) begin
            logic [31:0] w;
            w = tb_mem[ram_addr];
            ram_rdata <= w;
            for (int b = 0; b < 4; b++)
                if (ram_wstrb[b]) w[8*b +: 8] = ram_wdata[8*b +: 8];
            tb_mem[ram_addr] <= w;
        end
    end

    // Reference memory for the random phase, word indexed, default zero
    logic [31:0] ref_mem [int];

    typedef struct {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        region_t     region;
        int          lat;
        bit          chk_rd;
        logic [31:0] rdata;
        logic [15:0] raddr;
        bit          con;
        logic [7:0]  cdata;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Issue one request and watch it to completion (bounded). b2b means the
    // request is presented during the previous request's response cycle.
    task automatic do_req(input logic instr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input bit b2b,
                          output logic [31:0] rd, output int lat, output int nram,
                          output logic [15:0] ra, output logic [3:0] rs,
                          output int ncon, output logic [7:0] cd, output int rdy_at);
        int  cyc;
        bit  done;
        cpu_bus.cpu_valid = 1'b1;
        cpu_bus.cpu_instr = instr;
        cpu_bus.cpu_addr  = addr;
        cpu_bus.cpu_wdata = wdata;
        cpu_bus.cpu_wstrb = wstrb;
        cyc = b2b ? -1 : 0;
        done = 1'b0;
        rd = 32'h0; lat = -1; nram = 0; ra = 16'h0; rs = 4'h0; ncon = 0; cd = 8'h0; rdy_at = 0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (ram_valid) begin nram++; ra = ram_addr; rs = ram_wstrb; end
            if (console_valid) begin ncon++; cd = console_data; end
            if (cpu_bus.cpu_ready) begin
                rd = cpu_bus.cpu_rdata; lat = cyc; done = 1'b1; rdy_at = cycle_cnt;
            end
        end
    endtask

    task automatic gap();
        cpu_bus.cpu_valid = 1'b0;
        cpu_bus.cpu_wstrb = 4'h0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        cpu_bus.cpu_valid = 1'b0;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
    endtask

    vec_t        vt [16];
    logic [31:0] rd;
    int          lat, nram, ncon, rdy_at, prev_rdy, bad_period, nready;
    logic [15:0] ra;
    logic [3:0]  rs;
    logic [7:0]  cd;

    initial begin
        cpu_bus.cpu_valid = 1'b0;
        cpu_bus.cpu_instr = 1'b0;
        cpu_bus.cpu_addr  = 32'h0;
        cpu_bus.cpu_wdata = 32'h0;
        cpu_bus.cpu_wstrb = 4'h0;
        dec_addr  = 32'h0;
        dec_instr = 1'b0;
        resetn    = 1'b0;

        //          instr addr            wdata          wstrb    region       lat rd  rdata          raddr    con cdata
        vt[0]  = '{1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF,    REG_RAM,     2, 0, 32'h0,         16'h4,    0, 8'h0};
        vt[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0,    REG_RAM,     2, 1, 32'hDEAD_BEEF, 16'h4,    0, 8'h0};
        vt[2]  = '{1'b0, 32'h0000_0010, 32'h0055_0000, 4'b0100, REG_RAM,     2, 0, 32'h0,         16'h4,    0, 8'h0};
        vt[3]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0,    REG_RAM,     2, 1, 32'hDE55_BEEF, 16'h4,    0, 8'h0};
        vt[4]  = '{1'b1, 32'h0000_0010, 32'h0,         4'h0,    REG_RAM,     2, 1, 32'hDE55_BEEF, 16'h4,    0, 8'h0};
        vt[5]  = '{1'b0, 32'h0003_FFFC, 32'h0,         4'h0,    REG_RAM,     2, 1, 32'h0,         16'hFFFF, 0, 8'h0};
        vt[6]  = '{1'b0, MBASE,         32'h0000_0041, 4'hF,    REG_CONSOLE, 1, 1, 32'h0,         16'h0,    1, 8'h41};
        vt[7]  = '{1'b0, MBASE,         32'h0000_0042, 4'b0001, REG_CONSOLE, 1, 1, 32'h0,         16'h0,    1, 8'h42};
        vt[8]  = '{1'b0, MBASE,         32'h0000_0043, 4'b0010, REG_CONSOLE, 1, 1, 32'h0,         16'h0,    0, 8'h0};
        vt[9]  = '{1'b0, MBASE,         32'h0,         4'h0,    REG_CONSOLE, 1, 1, 32'h0,         16'h0,    0, 8'h0};
        vt[10] = '{1'b0, MBASE + 4,     32'h0000_0001, 4'hF,    REG_STATUS,  1, 0, 32'h0,         16'h0,    0, 8'h0};
        vt[11] = '{1'b0, MBASE + 4,     32'h0,         4'h0,    REG_STATUS,  1, 1, 32'h3,         16'h0,    0, 8'h0};
        vt[12] = '{1'b0, 32'h0000_0002, 32'h0,         4'h0,    REG_FAULT,   1, 1, 32'h0,         16'h0,    0, 8'h0};
        vt[13] = '{1'b1, MBASE,         32'h0,         4'h0,    REG_FAULT,   1, 1, 32'h0,         16'h0,    0, 8'h0};
        vt[14] = '{1'b0, 32'h0004_0000, 32'h0,         4'h0,    REG_FAULT,   1, 1, 32'h0,         16'h0,    0, 8'h0};
        vt[15] = '{1'b0, MBASE + 8,     32'h0,         4'h0,    REG_FAULT,   1, 1, 32'h0,         16'h0,    0, 8'h0};

        do_reset();

        // Reset state
        chk("rst_cpu_ready", {31'b0, cpu_bus.cpu_ready}, 32'h0);
        chk("rst_cpu_rdata", cpu_bus.cpu_rdata, 32'h0);
        chk("rst_ram_valid", {31'b0, ram_valid}, 32'h0);
        chk("rst_console_valid", {31'b0, console_valid}, 32'h0);
        chk("rst_flags", {28'b0, test_done, test_pass, fault, 1'b0}, 32'h0);
        chk("rst_fault_addr", fault_addr, 32'h0);
        chk("rst_req_count", req_count, 32'h0);
        gap();

        // Directed vector table
        for (int i = 0; i < 16; i++) begin
            dec_addr  = vt[i].addr;
            dec_instr = vt[i].instr;
            do_req(vt[i].instr, vt[i].addr, vt[i].wdata, vt[i].wstrb, 1'b0,
                   rd, lat, nram, ra, rs, ncon, cd, rdy_at);
            chk($sformatf("vec%0d_region", i), 32'(dec_region), 32'(vt[i].region));
            chk($sformatf("vec%0d_latency", i), lat, vt[i].lat);
            chk($sformatf("vec%0d_ram_pulses", i), nram, (vt[i].region == REG_RAM) ? 1 : 0);
            if (vt[i].region == REG_RAM) begin
                chk($sformatf("vec%0d_ram_addr", i), {16'h0, ra}, {16'h0, vt[i].raddr});
                chk($sformatf("vec%0d_ram_wstrb", i), {28'h0, rs}, {28'h0, vt[i].wstrb});
            end
            if (vt[i].chk_rd) chk($sformatf("vec%0d_rdata", i), rd, vt[i].rdata);
            chk($sformatf("vec%0d_console_pulses", i), ncon, vt[i].con ? 1 : 0);
            if (vt[i].con) chk($sformatf("vec%0d_console_data", i), {24'h0, cd}, {24'h0, vt[i].cdata});
            gap();
        end
        chk("fault_flag", {31'b0, fault}, 32'h1);
        chk("fault_addr_first", fault_addr, 32'h0000_0002);
        chk("status_done_pass", {30'b0, test_pass, test_done}, 32'h3);
        chk("req_count_table", req_count, 32'd16);

        // A later status write with a non-pass value clears pass but keeps done
        do_req(1'b0, MBASE + 4, 32'h0000_0002, 4'b0001, 1'b0, rd, lat, nram, ra, rs, ncon, cd, rdy_at);
        gap();
        do_req(1'b0, MBASE + 4, 32'h0, 4'h0, 1'b0, rd, lat, nram, ra, rs, ncon, cd, rdy_at);
        chk("status_overwrite_rdata", rd, 32'h1);
        gap();
        chk("req_count_after_status", req_count, 32'd18);

        // Reset in the middle of a RAM write abandons it
        do_req(1'b0, 32'h0000_0020, 32'h1234_5678, 4'hF, 1'b0, rd, lat, nram, ra, rs, ncon, cd, rdy_at);
        gap();
        cpu_bus.cpu_valid = 1'b1;
        cpu_bus.cpu_instr = 1'b0;
        cpu_bus.cpu_addr  = 32'h0000_0020;
        cpu_bus.cpu_wdata = 32'hCAFE_F00D;
        cpu_bus.cpu_wstrb = 4'hF;
        @(negedge clk);
        chk("abort_in_ram_req", {31'b0, ram_valid}, 32'h1);
        resetn = 1'b0;
        #1;
        chk("abort_ram_valid_masked", {31'b0, ram_valid}, 32'h0);
        cpu_bus.cpu_valid = 1'b0;
        nready = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (cpu_bus.cpu_ready) nready++;
        end
        resetn = 1'b1;
        chk("abort_no_ready", nready, 0);
        chk("abort_flags_clear", {28'b0, test_done, test_pass, fault, 1'b0}, 32'h0);
        chk("abort_fault_addr_clear", fault_addr, 32'h0);
        chk("abort_req_count_clear", req_count, 32'h0);
        gap();
        do_req(1'b0, 32'h0000_0020, 32'h0, 4'h0, 1'b0, rd, lat, nram, ra, rs, ncon, cd, rdy_at);
        chk("abort_old_value_kept", rd, 32'h1234_5678);
        gap();

        // Random back-to-back RAM traffic against the reference memory
        do_reset();
        gap();
        bad_period = 0;
        prev_rdy = 0;
        for (int n = 0; n < 1000; n++) begin
            int          idx;
            logic [3:0]  ws;
            logic [31:0] wd;
            logic [31:0] exp;
            logic        ins;
            idx = 256 + int'($urandom_range(0, 63));
            ws  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            wd  = $urandom;
            ins = (ws == 4'h0) ? 1'($urandom_range(0, 1)) : 1'b0;
            exp = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
            do_req(ins, 32'(idx * 4), wd, ws, n != 0, rd, lat, nram, ra, rs, ncon, cd, rdy_at);
            chk($sformatf("rand%0d_latency", n), lat, 2);
            if (ws == 4'h0) begin
                chk($sformatf("rand%0d_rdata", n), rd, exp);
            end else begin
                for (int b = 0; b < 4; b++)
                    if (ws[b]) exp[8*b +: 8] = wd[8*b +: 8];
                ref_mem[idx] = exp;
            end
            if (n != 0 && (rdy_at - prev_rdy) != 3) bad_period++;
            prev_rdy = rdy_at;
        end
        gap();
        chk("rand_period_violations", bad_period, 0);
        chk("rand_req_count", req_count, 32'd1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_mem_bridge.md
# riscv_mem_bridge

Sits between the RISC-V core's native memory port (valid/ready, byte addresses) and the word-addressed single-port RAM. It handles the following:
- Decodes each request into RAM, MMIO or fault.
- Converts byte addresses to word addresses.
- Sequences the RAM's registered read data back to the core.
- Implements the verification MMIO: a console byte port and a test-status register.

It is the only master of the RAM.

## Interface
Parameters:
- ADDR_WIDTH, 16, RAM word-address width; RAM spans bytes 0 .. 4·2^ADDR_WIDTH−1
- MMIO_BASE, 32'h1000_0000, console register address; status register at MMIO_BASE+4

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- cpu_valid  in  1  core request; held until cpu_ready
- cpu_instr  in  1  request is an instruction fetch
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  write data
- cpu_wstrb  in  4  byte enables; 0 = read
- cpu_rdata  out  32  read data, valid when cpu_ready=1
- cpu_ready  out  1  one-cycle completion pulse
- ram_valid  out  1  RAM access strobe
- ram_instr  out  1  forwarded cpu_instr
- ram_addr  out  ADDR_WIDTH  word address = cpu_addr[ADDR_WIDTH+1:2]
- ram_wdata  out  32  forwarded write data
- ram_wstrb  out  4  forwarded byte enables
- ram_rdata  in  32  RAM registered read data
- console_valid  out  1  one-cycle pulse per console write
- console_data  out  8  console byte
- test_done  out  1  sticky, set by any status write
- test_pass  out  1  status written with 32'h1
- fault  out  1  sticky illegal-access flag
- fault_addr  out  32  address of first faulting request
- req_count  out  32  completed requests, wraps at 2^32

## Operation
- Decode is performed on cpu_valid in IDLE, in the following priority order:
  1. Misaligned (cpu_addr[1:0]≠0): FAULT.
  2. cpu_addr < 4·2^ADDR_WIDTH: RAM.
  3. cpu_addr == MMIO_BASE or MMIO_BASE+4, with cpu_instr=0: MMIO.
  4. Otherwise: FAULT (this includes instruction fetches from MMIO).
- Request fields are registered in IDLE; later states use only the registered copy.
- State machine:
  - IDLE → RAM_REQ (RAM region).
  - IDLE → RESP (MMIO or FAULT).
  - RAM_REQ → RESP.
  - RESP → IDLE.
- RAM_REQ:
  - ram_valid=1 for exactly one cycle, with registered addr/wdata/wstrb/instr.
  - The RAM performs the write and captures the old word into ram_rdata.
- RESP:
  - cpu_ready=1.
  - RAM: cpu_rdata=ram_rdata. A read returns the current word; a write returns the pre-write word, which the core ignores.
  - MMIO console: cpu_rdata=0. If wstrb[0]=1, console_valid=1 and console_data=wdata[7:0]. A console write with wstrb[0]=0 is a no-op.
  - MMIO status read: cpu_rdata={30'b0,test_pass,test_done}.
  - MMIO status write (any wstrb≠0): test_done←1, test_pass←(wdata==32'h1). A later write overwrites test_pass.
  - FAULT: cpu_rdata=0, no RAM access. fault←1; fault_addr is captured only if fault was 0.
  - req_count increments by 1.
- ram_valid, cpu_ready and console_valid are never asserted outside their named states.

## Timing
- Reset values: all outputs 0, state IDLE.
- A reset asserted mid-transaction abandons the request:
  - no cpu_ready is issued;
  - a RAM write in RAM_REQ during the reset cycle is suppressed (ram_valid=0);
  - fault, fault_addr, test_done, test_pass and req_count clear.
- Latency, counting cpu_valid first seen in IDLE as cycle 0:
  - RAM: ram_valid in cycle 1, cpu_ready in cycle 2.
  - MMIO/FAULT: cpu_ready in cycle 1.
- The core drops cpu_valid in the cycle after cpu_ready. IDLE accepts a new request in that same cycle if valid is already high again, so back-to-back RAM requests complete every 3 cycles.
- cpu_valid deasserting before cpu_ready is a protocol violation. The bridge completes the latched request regardless.
- req_count wraps 32'hFFFF_FFFF → 0.

## Structure
- Package riscv_mem_pkg holds:
  - state enum {IDLE, RAM_REQ, RESP};
  - region enum {REG_RAM, REG_CONSOLE, REG_STATUS, REG_FAULT};
  - MMIO offsets CONSOLE_OFS=0 and STATUS_OFS=4;
  - constant TEST_PASS_CODE=32'h1.
- Sub-module riscv_addr_decode is combinational: (addr, instr) → region. It is reused by the bench scoreboard.

## Test plan
- Write 32'hDEAD_BEEF with wstrb 4'hF to 0x0000_0010, then read 0x10:
  - ram_addr=4, ram_valid in cycle 1, cpu_ready in cycle 2;
  - the read returns 32'hDEAD_BEEF.
- Byte write of 0x55 with wstrb 4'b0100 at 0x10, then read → 32'hDE55_BEEF.
- Write 0x41 to MMIO_BASE, then 0x42 → two console_valid pulses, data 0x41 then 0x42, each with cpu_ready in cycle 1. Write 32'h1 to MMIO_BASE+4 → test_done=1, test_pass=1; reading it back returns 32'h3.
- Read 0x0000_0002, then fetch from MMIO_BASE:
  - both complete in 1 cycle with rdata 0 and no ram_valid;
  - fault=1, fault_addr=0x0000_0002.
- Assert resetn=0 during RAM_REQ of a write to 0x20 → no cpu_ready, and 0x20 retains its old value on a later read.
- 1000 back-to-back random RAM requests → req_count=1000 and a 3-cycle request period. The reference model matches every read.
